seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 32 +++
 rtl/seq_alu_iter.sv | 84 ++++++++
 rtl/seq_alu.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for the sequential ALU and its iterative datapath.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_SL  = 4'd3,
    OP_DIV = 4'd4,
    OP_MOD = 4'd5,
    OP_NOT = 4'd6,
    OP_OR  = 4'd7,
    OP_AND = 4'd8,
    OP_XOR = 4'd9,
    OP_EQ  = 4'd10,
    OP_NEQ = 4'd11,
    OP_LT  = 4'd12,
    OP_LE  = 4'd13,
    OP_GT  = 4'd14,
    OP_GE  = 4'd15
  } alu_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_ITER
  } state_e;

  function automatic logic is_div_op(alu_op_e o);
    return (o == OP_DIV) || (o == OP_MOD);
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Multicycle datapath: shift-add multiply or restoring divide, one bit per step.
module seq_alu_iter #(
  parameter int unsigned WORD_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic                 div_mode,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  output logic [WORD_SIZE-1:0] acc_next,
  output logic [WORD_SIZE-1:0] quo_next,
  output logic                 last
);

  localparam int unsigned CW = $clog2(WORD_SIZE) + 1;

  // r: product accumulator / partial remainder; x: multiplier / dividend-quotient;
  // y: shifted multiplicand / divisor
  logic [WORD_SIZE-1:0] r_q, r_d, x_q, x_d, y_q, y_d;
  logic [WORD_SIZE-1:0] r_step, x_step, y_step;
  logic [WORD_SIZE:0]   sh, diff;
  logic                 ge;
  logic                 div_q, div_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  always_comb begin
    sh   = {r_q, x_q[WORD_SIZE-1]};
    diff = sh - {1'b0, y_q};
    ge   = ~diff[WORD_SIZE];
    if (div_q) begin
      r_step = ge ? diff[WORD_SIZE-1:0] : sh[WORD_SIZE-1:0];
      x_step = {x_q[WORD_SIZE-2:0], ge};
      y_step = y_q;
    end else begin
      r_step = r_q + (x_q[0] ? y_q : '0);
      x_step = x_q >> 1;
      y_step = y_q << 1;
    end
  end

  always_comb begin
    r_d   = r_q;
    x_d   = x_q;
    y_d   = y_q;
    div_d = div_q;
    cnt_d = cnt_q;
    if (load) begin
      r_d   = '0;
      x_d   = div_mode ? a : b;
      y_d   = div_mode ? b : a;
      div_d = div_mode;
      cnt_d = '0;
    end else if (step) begin
      r_d   = r_step;
      x_d   = x_step;
      y_d   = y_step;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      r_q   <= r_d;
      x_q   <= x_d;
      y_q   <= y_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  // Final step's values are taken combinationally so the result lands on the W-th edge.
  assign acc_next = r_step;
  assign quo_next = x_step;
  assign last     = (cnt_q == CW'(WORD_SIZE - 1));

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/compare ops plus multicycle MUL/DIV/MOD.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [3:0]           op,
  input  logic [WORD_SIZE-1:0] A,
  input  logic [WORD_SIZE-1:0] B,
  output logic                 ready,
  output logic                 done,
  output logic [WORD_SIZE-1:0] out,
  output logic                 zero,
  output logic                 div_by_zero
);

  localparam logic [WORD_SIZE-1:0] WS = WORD_SIZE'(WORD_SIZE);

  state_e               state_q, state_d;
  alu_op_e              op_q, op_d, op_in;
  logic [WORD_SIZE-1:0] out_q, out_d, single_res, acc_next, quo_next;
  logic                 zero_q, zero_d, dbz_q, dbz_d, done_q, done_d;
  logic                 load, step, iter_last;

  assign op_in = alu_op_e'(op);

  seq_alu_iter #(.WORD_SIZE(WORD_SIZE)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .div_mode (is_div_op(op_in)),
    .a        (A),
    .b        (B),
    .acc_next (acc_next),
    .quo_next (quo_next),
    .last     (iter_last)
  );

  always_comb begin
    single_res = '0;
    case (op_in)
      OP_ADD:  single_res = A + B;
      OP_SUB:  single_res = A - B;
      OP_SL:   single_res = (B >= WS) ? '0 : (A << B);
      OP_DIV:  single_res = '1;
      OP_MOD:  single_res = A;
      OP_NOT:  single_res = ~A;
      OP_OR:   single_res = A | B;
      OP_AND:  single_res = A & B;
      OP_XOR:  single_res = A ^ B;
      OP_EQ:   single_res[0] = (A == B);
      OP_NEQ:  single_res[0] = (A != B);
      OP_LT:   single_res[0] = (A < B);
      OP_LE:   single_res[0] = (A <= B);
      OP_GT:   single_res[0] = (A > B);
      OP_GE:   single_res[0] = (A >= B);
      default: single_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    out_d   = out_q;
    zero_d  = zero_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op_in == OP_MUL || (is_div_op(op_in) && B != '0)) begin
            load    = 1'b1;
            op_d    = op_in;
            state_d = ST_ITER;
          end else begin
            out_d  = single_res;
            zero_d = (single_res == '0);
            dbz_d  = is_div_op(op_in);
            done_d = 1'b1;
          end
        end
      end
      ST_ITER: begin
        step = 1'b1;
        if (iter_last) begin
          out_d   = (op_q == OP_DIV) ? quo_next : acc_next;
          zero_d  = (out_d == '0);
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      out_q   <= '0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign ready       = (state_q == ST_IDLE);
  assign done        = done_q;
  assign out         = out_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;

endmodule
